// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control unit.
// Runs each instruction through FETCH/DECODE/EXEC/(MEM)/WB over one shared
// memory port. Illegal encodings and memory timeouts halt the core in TRAP,
// and only reset leaves TRAP.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALU_CW      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inst,
    input  logic              BrEq,
    input  logic              BrLT,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              MemRW,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              PCSel,
    output logic [2:0]        ImmSel,
    output logic              ASel,
    output logic              BSel,
    output logic              BrUn,
    output logic              RegWEn,
    output logic [1:0]        WBSel,
    output logic [ALU_CW-1:0] ALU_control,
    output logic              retire,
    output logic              trap,
    output logic [1:0]        trap_cause
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALU_CW-1:0] ALU_ADD   = ALU_CW'(7'b0011100);
    localparam logic [ALU_CW-1:0] ALU_SUB   = ALU_CW'(7'b0011101);
    localparam logic [ALU_CW-1:0] ALU_SLL   = ALU_CW'(7'b0011110);
    localparam logic [ALU_CW-1:0] ALU_SLT   = ALU_CW'(7'b0011111);
    localparam logic [ALU_CW-1:0] ALU_SLTU  = ALU_CW'(7'b0100000);
    localparam logic [ALU_CW-1:0] ALU_XOR   = ALU_CW'(7'b0100001);
    localparam logic [ALU_CW-1:0] ALU_SRL   = ALU_CW'(7'b0100010);
    localparam logic [ALU_CW-1:0] ALU_SRA   = ALU_CW'(7'b0100011);
    localparam logic [ALU_CW-1:0] ALU_OR    = ALU_CW'(7'b0100100);
    localparam logic [ALU_CW-1:0] ALU_AND   = ALU_CW'(7'b0100101);
    localparam logic [ALU_CW-1:0] ALU_PASSB = ALU_CW'(7'b0100110);
    localparam logic [ALU_CW-1:0] ALU_IDLE  = '1;

    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_B = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        taken_q, taken_d;
    logic [1:0]  cause_q, cause_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        isOp, isOpImm, isLoad, isStore, isBranch;
    logic        isJal, isJalr, isLui, isAuipc;
    logic        illegal;
    logic        branchCond;
    logic [ALU_CW-1:0] aluFromFunct;
    logic        unusedInst;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Register numbers and rd belong to the datapath; this unit never needs them.
    assign unusedInst = ^{inst[24:15], inst[11:7]};

    assign isOp     = (opcode == OPC_OP);
    assign isOpImm  = (opcode == OPC_OPIMM);
    assign isLoad   = (opcode == OPC_LOAD);
    assign isStore  = (opcode == OPC_STORE);
    assign isBranch = (opcode == OPC_BRANCH);
    assign isJal    = (opcode == OPC_JAL);
    assign isJalr   = (opcode == OPC_JALR);
    assign isLui    = (opcode == OPC_LUI);
    assign isAuipc  = (opcode == OPC_AUIPC);

    // Instruction classification: legality, ALU op of register/immediate arithmetic, branch outcome.
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_OP:     illegal = !((funct7 == 7'b0000000) ||
                                    ((funct7 == 7'b0100000) &&
                                     ((funct3 == 3'b000) || (funct3 == 3'b101))));
            OPC_OPIMM: begin
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                end
            end
            OPC_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_JALR:   illegal = (funct3 != 3'b000);
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_LUI, OPC_AUIPC: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase

        aluFromFunct = ALU_ADD;
        case (funct3)
            3'b000:  aluFromFunct = (isOp && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  aluFromFunct = ALU_SLL;
            3'b010:  aluFromFunct = ALU_SLT;
            3'b011:  aluFromFunct = ALU_SLTU;
            3'b100:  aluFromFunct = ALU_XOR;
            3'b101:  aluFromFunct = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  aluFromFunct = ALU_OR;
            default: aluFromFunct = ALU_AND;
        endcase

        branchCond = 1'b0;
        case (funct3)
            3'b000:         branchCond = BrEq;
            3'b001:         branchCond = !BrEq;
            3'b100, 3'b110: branchCond = BrLT;
            3'b101, 3'b111: branchCond = !BrLT;
            default:        branchCond = 1'b0;
        endcase
    end

    // State, wait counter, branch decision and trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
            taken_q   <= 1'b0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            taken_q   <= taken_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state and Moore strobes; the counter stays at zero unless a request is waiting.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = '0;
        taken_d     = taken_q;
        cause_d     = cause_q;
        mem_req     = 1'b0;
        MemRW       = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSel       = 1'b0;
        ImmSel      = IMM_R;
        ASel        = 1'b0;
        BSel        = 1'b0;
        BrUn        = 1'b0;
        RegWEn      = 1'b0;
        WBSel       = 2'd0;
        ALU_control = ALU_IDLE;
        retire      = 1'b0;
        trap        = 1'b0;
        trap_cause  = 2'd0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = DECODE;
                end else if (waitCnt_q == TIMEOUT_CNT) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            DECODE: begin
                if (illegal) begin
                    state_d = TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // LUI, AUIPC and the jumps still take the immediate on the B operand.
                ALU_control = ALU_ADD;
                taken_d     = 1'b0;
                if (isOp) begin
                    ALU_control = aluFromFunct;
                end else if (isOpImm) begin
                    ALU_control = aluFromFunct;
                    BSel        = 1'b1;
                    ImmSel      = IMM_I;
                end else if (isLoad) begin
                    BSel   = 1'b1;
                    ImmSel = IMM_I;
                end else if (isStore) begin
                    BSel   = 1'b1;
                    ImmSel = IMM_S;
                end else if (isLui) begin
                    ALU_control = ALU_PASSB;
                    BSel        = 1'b1;
                    ImmSel      = IMM_U;
                end else if (isAuipc) begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = IMM_U;
                end else if (isJal) begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = IMM_J;
                end else if (isJalr) begin
                    BSel   = 1'b1;
                    ImmSel = IMM_I;
                end else if (isBranch) begin
                    ASel    = 1'b1;
                    BSel    = 1'b1;
                    ImmSel  = IMM_B;
                    BrUn    = funct3[2] && funct3[1];
                    taken_d = branchCond;
                end
                state_d = (isLoad || isStore) ? MEM : WB;
            end
            MEM: begin
                mem_req = 1'b1;
                MemRW   = isStore;
                if (mem_ready) begin
                    state_d = WB;
                end else if (waitCnt_q == TIMEOUT_CNT) begin
                    state_d = TRAP;
                    cause_d = 2'd3;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            WB: begin
                retire  = 1'b1;
                PCWrite = 1'b1;
                PCSel   = isJal || isJalr || (isBranch && taken_q);
                RegWEn  = !(isStore || isBranch);
                if (isLoad) begin
                    WBSel = 2'd0;
                end else if (isJal || isJalr) begin
                    WBSel = 2'd2;
                end else begin
                    WBSel = 2'd1;
                end
                state_d = FETCH;
            end
            TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            mem_req     = 1'b0;
            MemRW       = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCSel       = 1'b0;
            ImmSel      = IMM_R;
            ASel        = 1'b0;
            BSel        = 1'b0;
            BrUn        = 1'b0;
            RegWEn      = 1'b0;
            WBSel       = 2'd0;
            ALU_control = ALU_IDLE;
            retire      = 1'b0;
            trap        = 1'b0;
            trap_cause  = 2'd0;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: expected per-instruction results are queued
// when an instruction is issued and compared as the DUT walks it through EXEC/MEM/WB.
module tb_riscv_multicycle_ctrl;

    localparam int TB_TIMEOUT = 15;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        brEq;
        logic        brLT;
        logic [6:0]  alu;
        logic [2:0]  imm;
        logic        aSel;
        logic        bSel;
        logic        chkB;
        logic        brUn;
        logic        isMem;
        logic        memRW;
        logic        pcSel;
        logic        regWEn;
        logic [1:0]  wbSel;
    } expRec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        BrEq, BrLT, mem_ready;
    logic        mem_req, MemRW, IRWrite, PCWrite, PCSel;
    logic [2:0]  ImmSel;
    logic        ASel, BSel, BrUn, RegWEn;
    logic [1:0]  WBSel;
    logic [6:0]  ALU_control;
    logic        retire, trap;
    logic [1:0]  trap_cause;

    expRec_t expQ[$];
    int nChecks = 0;
    int nFail   = 0;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .ALU_CW(7)) dut (
        .clk(clk), .reset(reset), .inst(inst), .BrEq(BrEq), .BrLT(BrLT),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRW(MemRW), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSel(PCSel), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel),
        .BrUn(BrUn), .RegWEn(RegWEn), .WBSel(WBSel), .ALU_control(ALU_control),
        .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    // 10-time-unit core clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic expRec_t mkRec(input string name, input logic [31:0] instr,
                                      input logic brEq, input logic brLT,
                                      input logic [6:0] alu, input logic [2:0] imm,
                                      input logic aSel, input logic bSel, input logic chkB,
                                      input logic brUn, input logic isMem, input logic memRW,
                                      input logic pcSel, input logic regWEn, input logic [1:0] wbSel);
        expRec_t r;
        r.name = name;  r.instr = instr; r.brEq = brEq; r.brLT = brLT;
        r.alu = alu;    r.imm = imm;     r.aSel = aSel; r.bSel = bSel; r.chkB = chkB;
        r.brUn = brUn;  r.isMem = isMem; r.memRW = memRW;
        r.pcSel = pcSel; r.regWEn = regWEn; r.wbSel = wbSel;
        return r;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_req"}, mem_req, 0);
        checkOutput({tag, " MemRW"}, MemRW, 0);
        checkOutput({tag, " IRWrite"}, IRWrite, 0);
        checkOutput({tag, " PCWrite"}, PCWrite, 0);
        checkOutput({tag, " PCSel"}, PCSel, 0);
        checkOutput({tag, " ImmSel"}, ImmSel, 0);
        checkOutput({tag, " ASel"}, ASel, 0);
        checkOutput({tag, " BSel"}, BSel, 0);
        checkOutput({tag, " BrUn"}, BrUn, 0);
        checkOutput({tag, " RegWEn"}, RegWEn, 0);
        checkOutput({tag, " WBSel"}, WBSel, 0);
        checkOutput({tag, " ALU_control"}, ALU_control, 7'h7F);
        checkOutput({tag, " retire"}, retire, 0);
        checkOutput({tag, " trap"}, trap, 0);
        checkOutput({tag, " trap_cause"}, trap_cause, 0);
    endtask

    // Called just after a rising edge; leaves the DUT in FETCH with reset released.
    task automatic doReset(input string tag);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checkAllZero({tag, " in-reset"});
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkOutput({tag, " post-reset mem_req"}, mem_req, 1);
        checkOutput({tag, " post-reset trap"}, trap, 0);
        checkOutput({tag, " post-reset trap_cause"}, trap_cause, 0);
    endtask

    // Issue one instruction and follow it to retirement.
    task automatic applyStimulus(input expRec_t e, input int fetchWaits, input int memWaits);
        expRec_t cur;
        expQ.push_back(e);
        inst = e.instr;
        BrEq = e.brEq;
        BrLT = e.brLT;
        for (int i = 0; i < fetchWaits; i++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            checkOutput({e.name, " fetch-wait mem_req"}, mem_req, 1);
            checkOutput({e.name, " fetch-wait IRWrite"}, IRWrite, 0);
            checkOutput({e.name, " fetch-wait trap"}, trap, 0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput({e.name, " fetch mem_req"}, mem_req, 1);
        checkOutput({e.name, " fetch MemRW"}, MemRW, 0);
        checkOutput({e.name, " fetch IRWrite"}, IRWrite, 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput({e.name, " decode mem_req"}, mem_req, 0);
        checkOutput({e.name, " decode ALU_control"}, ALU_control, 7'h7F);
        checkOutput({e.name, " decode retire"}, retire, 0);
        @(posedge clk); #1;
        @(negedge clk);
        cur = expQ[0];
        checkOutput({cur.name, " exec ALU_control"}, ALU_control, cur.alu);
        checkOutput({cur.name, " exec ImmSel"}, ImmSel, cur.imm);
        checkOutput({cur.name, " exec ASel"}, ASel, cur.aSel);
        if (cur.chkB) checkOutput({cur.name, " exec BSel"}, BSel, cur.bSel);
        checkOutput({cur.name, " exec BrUn"}, BrUn, cur.brUn);
        checkOutput({cur.name, " exec retire"}, retire, 0);
        checkOutput({cur.name, " exec mem_req"}, mem_req, 0);
        @(posedge clk); #1;
        if (cur.isMem) begin
            for (int i = 0; i <= memWaits; i++) begin
                mem_ready = (i == memWaits);
                @(negedge clk);
                checkOutput({cur.name, " mem mem_req"}, mem_req, 1);
                checkOutput({cur.name, " mem MemRW"}, MemRW, cur.memRW);
                checkOutput({cur.name, " mem retire"}, retire, 0);
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
        end
        @(negedge clk);
        cur = expQ.pop_front();
        checkOutput({cur.name, " wb retire"}, retire, 1);
        checkOutput({cur.name, " wb PCWrite"}, PCWrite, 1);
        checkOutput({cur.name, " wb PCSel"}, PCSel, cur.pcSel);
        checkOutput({cur.name, " wb RegWEn"}, RegWEn, cur.regWEn);
        checkOutput({cur.name, " wb WBSel"}, WBSel, cur.wbSel);
        checkOutput({cur.name, " wb mem_req"}, mem_req, 0);
        checkOutput({cur.name, " wb ALU_control"}, ALU_control, 7'h7F);
        @(posedge clk); #1;
    endtask

    task automatic runIllegal(input string tag, input logic [31:0] instr);
        inst = instr;
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, " IRWrite"}, IRWrite, 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, " decode trap"}, trap, 0);
        checkOutput({tag, " decode retire"}, retire, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            @(negedge clk);
            checkOutput({tag, " trap"}, trap, 1);
            checkOutput({tag, " trap_cause"}, trap_cause, 1);
            checkOutput({tag, " trapped mem_req"}, mem_req, 0);
            checkOutput({tag, " trapped retire"}, retire, 0);
            checkOutput({tag, " trapped IRWrite"}, IRWrite, 0);
            @(posedge clk); #1;
        end
        doReset(tag);
    endtask

    // Let a fetch (cause 2) or data access (cause 3) wait until the limit expires.
    task automatic runTimeout(input string tag, input logic [31:0] instr, input logic [1:0] cause);
        inst = instr;
        if (cause == 2'd3) begin
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        for (int i = 0; i <= TB_TIMEOUT; i++) begin
            @(negedge clk);
            checkOutput({tag, " wait mem_req"}, mem_req, 1);
            checkOutput({tag, " wait trap"}, trap, 0);
            if (cause == 2'd3) checkOutput({tag, " wait MemRW"}, MemRW, 1);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checkOutput({tag, " trap"}, trap, 1);
            checkOutput({tag, " trap_cause"}, trap_cause, cause);
            checkOutput({tag, " trapped mem_req"}, mem_req, 0);
            checkOutput({tag, " trapped IRWrite"}, IRWrite, 0);
            checkOutput({tag, " trapped retire"}, retire, 0);
            @(posedge clk); #1;
        end
        doReset(tag);
    endtask

    // Directed sequence.
    initial begin
        reset = 1'b1;
        inst = 32'h0;
        BrEq = 1'b0;
        BrLT = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        doReset("reset");

        applyStimulus(mkRec("ADD",  32'h002081B3, 0, 0, 7'h1C, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 2'd1), 0, 0);
        applyStimulus(mkRec("SUB",  32'h40208233, 0, 0, 7'h1D, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 2'd1), 0, 0);
        applyStimulus(mkRec("LW",   32'h0000A183, 0, 0, 7'h1C, 3'b001, 0, 1, 1, 0, 1, 0, 0, 1, 2'd0), 0, 3);
        applyStimulus(mkRec("SW",   32'h0020A023, 0, 0, 7'h1C, 3'b010, 0, 1, 1, 0, 1, 1, 0, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BNE",  32'h00209463, 0, 0, 7'h1C, 3'b100, 1, 1, 1, 0, 0, 0, 1, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BGE",  32'h0020D463, 0, 0, 7'h1C, 3'b100, 1, 1, 1, 0, 0, 0, 1, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BGEU", 32'h0020F463, 0, 0, 7'h1C, 3'b100, 1, 1, 1, 1, 0, 0, 1, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BEQ",  32'h00208463, 0, 0, 7'h1C, 3'b100, 1, 1, 1, 0, 0, 0, 0, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BLT",  32'h0020C463, 0, 0, 7'h1C, 3'b100, 1, 1, 1, 0, 0, 0, 0, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("BLTU", 32'h0020E463, 1, 1, 7'h1C, 3'b100, 1, 1, 1, 1, 0, 0, 1, 0, 2'd1), 0, 0);
        applyStimulus(mkRec("JAL",  32'h008000EF, 0, 0, 7'h1C, 3'b101, 1, 0, 0, 0, 0, 0, 1, 1, 2'd2), 0, 0);
        applyStimulus(mkRec("LUI",  32'h123450B7, 0, 0, 7'h26, 3'b011, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1), 0, 0);
        applyStimulus(mkRec("SRAI", 32'h4030D093, 0, 0, 7'h23, 3'b001, 0, 1, 1, 0, 0, 0, 0, 1, 2'd1), 0, 0);
        applyStimulus(mkRec("ADDI-slow", 32'h00500093, 0, 0, 7'h1C, 3'b001, 0, 1, 1, 0, 0, 0, 0, 1, 2'd1), TB_TIMEOUT, 0);

        runIllegal("ILLEGAL-OPC", 32'h0000007F);
        runIllegal("ILLEGAL-F7",  32'h022081B3);

        // Abandon an ADD by resetting while it sits in EXEC.
        inst = 32'h002081B3;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("RST-EXEC forced ALU_control", ALU_control, 7'h7F);
        @(posedge clk); #1;
        @(negedge clk);
        checkAllZero("RST-EXEC next");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("RST-EXEC refetch mem_req", mem_req, 1);
        checkOutput("RST-EXEC refetch retire", retire, 0);
        applyStimulus(mkRec("ADD-again", 32'h002081B3, 0, 0, 7'h1C, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 2'd1), 0, 0);

        runTimeout("FETCH-TIMEOUT", 32'h002081B3, 2'd2);
        runTimeout("DATA-TIMEOUT",  32'h0020A023, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
